// File: rtl/sr_pulse_sequencer_if.sv
// Request/response and latch-drive bundle for sr_pulse_sequencer.
interface sr_pulse_sequencer_if;
  logic set_req;
  logic rst_req;
  logic req_ready;
  logic set_ack;
  logic rst_ack;
  logic s;
  logic r;
  logic busy;
  logic q_exp;
  logic q_known;
  logic err_both;

  // Requester / observer side.
  modport master (
    output set_req,
    output rst_req,
    input  req_ready,
    input  set_ack,
    input  rst_ack,
    input  s,
    input  r,
    input  busy,
    input  q_exp,
    input  q_known,
    input  err_both
  );

  // Sequencer side.
  modport slave (
    input  set_req,
    input  rst_req,
    output req_ready,
    output set_ack,
    output rst_ack,
    output s,
    output r,
    output busy,
    output q_exp,
    output q_known,
    output err_both
  );
endinterface

// File: rtl/sr_pulse_sequencer.sv
// Drives the s/r inputs of a NOR SR latch bank: arbitrated requests become fixed-width
// pulses followed by a quiet gap, while tracking the latch's expected state.
module sr_pulse_sequencer #(
  parameter int unsigned PULSE_W = 3,
  parameter int unsigned GAP_W   = 2
) (
  input logic                 clk,
  input logic                 reset,
  sr_pulse_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

  localparam logic [3:0] PulseCnt = 4'(PULSE_W - 1);
  localparam logic [3:0] GapCnt   = 4'(GAP_W - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pri_q, pri_d;     // 0: set preferred, 1: reset preferred
  logic       cmd_q, cmd_d;     // 1: current command is a set
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       set_ack_q, set_ack_d;
  logic       rst_ack_q, rst_ack_d;
  logic       err_q, err_d;
  logic       q_exp_q, q_exp_d;
  logic       q_known_q, q_known_d;

  logic set_win, rst_win;

  // Rotating-priority arbitration between the two requesters.
  always_comb begin
    set_win = bus.set_req & (~bus.rst_req | ~pri_q);
    rst_win = bus.rst_req & (~bus.set_req | pri_q);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pri_d     = pri_q;
    cmd_d     = cmd_q;
    s_d       = 1'b0;
    r_d       = 1'b0;
    set_ack_d = 1'b0;
    rst_ack_d = 1'b0;
    err_d     = 1'b0;
    q_exp_d   = q_exp_q;
    q_known_d = q_known_q;
    unique case (state_q)
      StIdle: begin
        if (set_win || rst_win) begin
          state_d   = StPulse;
          cnt_d     = PulseCnt;
          cmd_d     = set_win;
          s_d       = set_win;
          r_d       = rst_win;
          set_ack_d = set_win;
          rst_ack_d = rst_win;
          err_d     = bus.set_req & bus.rst_req;
          // Point priority away from the request just served.
          pri_d     = set_win;
        end
      end
      StPulse: begin
        if (cnt_q == 4'd0) begin
          state_d   = StGap;
          cnt_d     = GapCnt;
          q_exp_d   = cmd_q;
          q_known_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          s_d   = cmd_q;
          r_d   = ~cmd_q;
        end
      end
      StGap: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset truncates any pulse and forgets the latch state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      pri_q     <= 1'b0;
      cmd_q     <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      set_ack_q <= 1'b0;
      rst_ack_q <= 1'b0;
      err_q     <= 1'b0;
      q_exp_q   <= 1'b0;
      q_known_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pri_q     <= pri_d;
      cmd_q     <= cmd_d;
      s_q       <= s_d;
      r_q       <= r_d;
      set_ack_q <= set_ack_d;
      rst_ack_q <= rst_ack_d;
      err_q     <= err_d;
      q_exp_q   <= q_exp_d;
      q_known_q <= q_known_d;
    end
  end

  // Outputs come straight from registers; ready/busy decode state only.
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.busy      = (state_q != StIdle);
    bus.s         = s_q;
    bus.r         = r_q;
    bus.set_ack   = set_ack_q;
    bus.rst_ack   = rst_ack_q;
    bus.err_both  = err_q;
    bus.q_exp     = q_exp_q;
    bus.q_known   = q_known_q;
  end

endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// Scoreboard bench for sr_pulse_sequencer with default PULSE_W=3, GAP_W=2.
module tb_sr_pulse_sequencer;

  localparam int PW = 3;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sr_pulse_sequencer_if bus ();

  sr_pulse_sequencer #(.PULSE_W(PW), .GAP_W(GW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic is_set;
    logic both;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic pri_m = 1'b0;
  int   acks_seen = 0;
  int   rises_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive requests for this cycle; if the sequencer is ready, the coming edge accepts,
  // so predict the winner from the bench's own priority flag.
  task automatic drive(input logic a, input logic b);
    exp_t e;
    bus.set_req = a;
    bus.rst_req = b;
    #0;
    if (!reset && bus.req_ready && (a || b)) begin
      e.is_set = a && (!b || !pri_m);
      e.both   = a && b;
      sb_q.push_back(e);
      pri_m = e.is_set;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    drive(1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    pri_m = 1'b0;
  endtask

  task automatic wait_ack(input logic a, input logic b, output int at);
    int n = 0;
    at = -1;
    while (n < 20) begin
      drive(a, b);
      tick();
      n++;
      if (bus.set_ack || bus.rst_ack) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    drive(1'b0, 1'b0);
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, bus.req_ready}, 32'd1);
  endtask

  // Monitor on the falling edge: invariants, ack scoreboard, pulse width and gap.
  int   run = 0;
  int   zero_len = 1000;
  logic kind = 1'b0;
  logic abort = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    check("s_and_r", {31'd0, bus.s & bus.r}, 32'd0);
    check("ready_busy", {31'd0, bus.req_ready}, {31'd0, ~bus.busy});
    if (bus.set_ack || bus.rst_ack) begin
      acks_seen++;
      if (sb_q.size() == 0) begin
        check("ack_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("ack_set", {31'd0, bus.set_ack}, {31'd0, e.is_set});
        check("ack_rst", {31'd0, bus.rst_ack}, {31'd0, ~e.is_set});
        check("err_both", {31'd0, bus.err_both}, {31'd0, e.both});
      end
    end else begin
      check("err_alone", {31'd0, bus.err_both}, 32'd0);
    end
    if (bus.s || bus.r) begin
      if (run == 0) begin
        rises_seen++;
        if (!abort) check("gap_len", {31'd0, zero_len >= GW}, 32'd1);
        abort = 1'b0;
        kind  = bus.s;
      end
      run++;
      zero_len = 0;
    end else begin
      if (run > 0 && !abort) begin
        check("pulse_w", run, PW);
        check("q_exp_upd", {31'd0, bus.q_exp}, {31'd0, kind});
        check("q_known_upd", {31'd0, bus.q_known}, 32'd1);
      end
      run = 0;
      zero_len++;
    end
    if (reset) begin
      abort = 1'b1;
      zero_len = 1000;
    end
  end

  initial begin
    int t0, t1, a0, p0;
    bus.set_req = 1'b0;
    bus.rst_req = 1'b0;

    // Reset and idle.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      check("idle_s", {31'd0, bus.s}, 32'd0);
      check("idle_r", {31'd0, bus.r}, 32'd0);
      check("idle_ready", {31'd0, bus.req_ready}, 32'd1);
      check("idle_qk", {31'd0, bus.q_known}, 32'd0);
      check("idle_qe", {31'd0, bus.q_exp}, 32'd0);
      tick();
    end

    // Single set with exact timing.
    drive(1'b1, 1'b0);
    check("ss_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    check("ss_ack", {31'd0, bus.set_ack}, 32'd1);
    check("ss_s1", {31'd0, bus.s}, 32'd1);
    check("ss_busy", {31'd0, bus.busy}, 32'd1);
    drive(1'b0, 1'b0);
    tick();
    check("ss_s2", {31'd0, bus.s}, 32'd1);
    check("ss_ack_once", {31'd0, bus.set_ack}, 32'd0);
    tick();
    check("ss_s3", {31'd0, bus.s}, 32'd1);
    check("ss_qk_late", {31'd0, bus.q_known}, 32'd0);
    tick();
    check("ss_gap1", {31'd0, bus.s}, 32'd0);
    check("ss_qe", {31'd0, bus.q_exp}, 32'd1);
    check("ss_qk", {31'd0, bus.q_known}, 32'd1);
    tick();
    check("ss_gap2", {31'd0, bus.s}, 32'd0);
    check("ss_notready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    check("ss_ready_again", {31'd0, bus.req_ready}, 32'd1);

    // Both held after a set: reset wins first, then alternation every 6 cycles.
    wait_ack(1'b1, 1'b1, t0);
    check("alt_first_rst", {31'd0, bus.rst_ack}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      wait_ack(1'b1, 1'b1, t1);
      check("alt_period", t1 - t0, PW + GW + 1);
      t0 = t1;
    end
    wait_idle();
    check("alt_qe_last", {31'd0, bus.q_exp}, 32'd1);

    // Simultaneous requests straight out of reset: set first.
    reset_dut();
    wait_ack(1'b1, 1'b1, t0);
    check("sim_set_first", {31'd0, bus.set_ack}, 32'd1);
    check("sim_err", {31'd0, bus.err_both}, 32'd1);
    wait_ack(1'b1, 1'b1, t1);
    check("sim_rst_second", {31'd0, bus.rst_ack}, 32'd1);
    check("sim_period", t1 - t0, 6);
    wait_idle();

    // Randomized requests; scoreboard checks arbitration, monitor the invariants.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    wait_idle();
    repeat (2) tick();
    check("rand_sb_empty", sb_q.size(), 0);

    // Reset during the second PULSE cycle of a reset command.
    drive(1'b0, 1'b1);
    tick();
    check("mr_rack", {31'd0, bus.rst_ack}, 32'd1);
    drive(1'b0, 1'b0);
    tick();
    check("mr_r_high", {31'd0, bus.r}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pri_m = 1'b0;
    check("mr_r", {31'd0, bus.r}, 32'd0);
    check("mr_busy", {31'd0, bus.busy}, 32'd0);
    check("mr_qk", {31'd0, bus.q_known}, 32'd0);
    check("mr_ready", {31'd0, bus.req_ready}, 32'd1);
    drive(1'b1, 1'b0);
    tick();
    check("mr_new_ack", {31'd0, bus.set_ack}, 32'd1);
    check("mr_new_s", {31'd0, bus.s}, 32'd1);
    wait_idle();

    // One-cycle set request while busy is ignored.
    a0 = acks_seen;
    p0 = rises_seen;
    drive(1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    repeat (10) tick();
    check("ign_acks", acks_seen - a0, 1);
    check("ign_pulses", rises_seen - p0, 1);
    check("final_sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
